// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ producers, the arbiter and the FIFO write pins.
// master: producers + FIFO side (drive req/din_bus/fifo_full)
// slave : the arbiter
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din_bus;
  logic [NREQ-1:0]    ack;
  logic               fifo_full;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_din;
  logic [2:0]         owner;
  logic               busy;

  modport master (
    output req, din_bus, fifo_full,
    input  ack, fifo_wr, fifo_din, owner, busy
  );

  modport slave (
    input  req, din_bus, fifo_full,
    output ack, fifo_wr, fifo_din, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A grant lasts until the owner drops req or MAX_BURST beats are accepted;
// acceptance in OWN is combinational so a beat costs no extra latency.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, OWN} state_e;

  state_e          state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      last_q,  last_d;
  logic [3:0]      beat_q,  beat_d;

  logic [NREQ-1:0] own_sel;   // one-hot decode of owner_q
  logic [NREQ-1:0] ack_lane;
  logic            is_own;
  logic            req_own;
  logic            wr;
  logic            any_req;
  logic [2:0]      winner;
  logic [DW-1:0]   din_mux;

  assign is_own  = (state_q == OWN);
  assign any_req = |bus.req;

  // Per-lane grant decode and acceptance; full blocks every lane.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign own_sel[i]  = (owner_q == 3'(i));
    assign ack_lane[i] = is_own & own_sel[i] & bus.req[i] & ~bus.fifo_full;
  end

  assign req_own = |(own_sel & bus.req);
  assign wr      = |ack_lane;

  // Rotating priority scan starting just after the last owner.
  always_comb begin
    logic found;
    int   idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        winner = 3'(idx);
        found  = 1'b1;
      end
    end
  end

  // Write data follows the owner; held at zero outside OWN (incl. reset).
  always_comb begin
    din_mux = '0;
    if (is_own) begin
      for (int i = 0; i < NREQ; i++) begin
        if (own_sel[i]) din_mux = bus.din_bus[i*DW +: DW];
      end
    end
  end

  // Next-state: grant in IDLE, count beats and release in OWN.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = OWN;
          owner_d = winner;
          beat_d  = '0;
        end
      end
      OWN: begin
        if (!req_own) begin
          // Owner withdrew; nothing was written this cycle.
          state_d = IDLE;
          last_d  = owner_q;
        end else if (wr) begin
          beat_d = beat_q + 4'd1;
          if (beat_q + 4'd1 == 4'(MAX_BURST)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset makes the next scan start at requester 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      beat_q  <= '0;
      last_q  <= 3'(NREQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
    end
  end

  assign bus.ack      = ack_lane;
  assign bus.fifo_wr  = wr;
  assign bus.fifo_din = din_mux;
  assign bus.owner    = owner_q;
  assign bus.busy     = is_own;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a grant/remaining-beats reference model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] din [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_din
    assign bus.din_bus[g*DW +: DW] = din[g];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current grant (-1 = none), beats still allowed, last owner.
  int m_own, m_rem, m_last;

  // What the DUT showed on the last sampled cycle.
  logic [NREQ-1:0] obs_ack;
  logic            obs_wr, obs_busy;
  logic [2:0]      obs_owner;
  logic [DW-1:0]   wq[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int scan(logic [NREQ-1:0] r, int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_rem  = 0;
    m_last = NREQ - 1;
  endtask

  task automatic model_step(bit wrote);
    int w;
    if (m_own < 0) begin
      w = scan(bus.req, m_last);
      if (w >= 0) begin
        m_own = w;
        m_rem = MB;
      end
    end else if (!bus.req[m_own]) begin
      m_last = m_own;
      m_own  = -1;
    end else if (wrote) begin
      m_rem--;
      if (m_rem == 0) begin
        m_last = m_own;
        m_own  = -1;
      end
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return 1 after.
  task automatic cycle();
    int ea;
    @(negedge clk);
    ea = 0;
    if (m_own >= 0 && bus.req[m_own] && !bus.fifo_full) ea = 1 << m_own;
    check("ack",  32'(bus.ack),     32'(ea));
    check("wr",   32'(bus.fifo_wr), 32'(ea != 0));
    check("busy", 32'(bus.busy),    32'(m_own >= 0));
    if (m_own >= 0) check("owner", 32'(bus.owner), 32'(m_own));
    if (ea != 0) check("din", 32'(bus.fifo_din), 32'(din[m_own]));
    if (!rst) check("rst_din", 32'(bus.fifo_din), 32'd0);
    obs_ack   = bus.ack;
    obs_wr    = bus.fifo_wr;
    obs_busy  = bus.busy;
    obs_owner = bus.owner;
    if (bus.fifo_wr) wq.push_back(bus.fifo_din);
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step(ea != 0);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    cycle();
    rst = 1'b1;
  endtask

  task automatic advance_din();
    for (int i = 0; i < NREQ; i++) if (obs_ack[i]) din[i] = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NREQ-1:0] r;
    logic [DW-1:0]   nxt;
    int              t;
    int              ackt[$];

    for (int i = 0; i < NREQ; i++) din[i] = 8'(i * 16);
    bus.req       = '0;
    bus.fifo_full = 1'b0;
    obs_ack       = '0;
    model_reset();

    // Reset with every requester asking: nothing may be granted.
    bus.req = 4'b1111;
    #2;
    check("rst_ack",  32'(bus.ack),     32'd0);
    check("rst_wr",   32'(bus.fifo_wr), 32'd0);
    check("rst_busy", 32'(bus.busy),    32'd0);
    check("rst_din0", 32'(bus.fifo_din), 32'd0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    check("rst_arb_noack", 32'(obs_wr), 32'd0);
    cycle();
    check("rst_first_ack",   32'(obs_ack),   32'b0001);
    check("rst_first_owner", 32'(obs_owner), 32'd0);
    bus.req = '0;
    cycle();
    cycle();

    // Single requester with a data sequence A0..A4.
    do_reset();
    wq.delete();
    nxt = 8'hA0;
    din[2] = nxt;
    bus.req = 4'b0100;
    t = 0;
    while (wq.size() < 5 && t < 20) begin
      cycle();
      if (obs_ack[2]) begin
        ackt.push_back(t);
        nxt = nxt + 8'd1;
        din[2] = nxt;
      end
      t++;
    end
    check("single_count", 32'(wq.size()), 32'd5);
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      check("single_data", 32'(wq[i]), 32'(8'hA0 + i));
    end
    for (int i = 0; i < 5 && i < ackt.size(); i++) begin
      check("single_ack_cycle", 32'(ackt[i]), 32'((i < 4) ? i + 1 : 6));
    end
    bus.req = '0;
    cycle();
    cycle();

    // Round robin with everyone requesting: 4 writes + 1 idle per grant.
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      cycle();
      check("rr_wr_pattern", 32'(obs_wr), 32'((k % 5) != 0));
      if (k % 5 == 1) check("rr_owner", 32'(obs_owner), 32'((k / 5) % 4));
      advance_din();
    end
    bus.req = '0;
    cycle();

    // Backpressure: owner 1 stalls after two beats, then finishes with two.
    do_reset();
    bus.req = 4'b0010;
    cycle();
    cycle();
    check("bp_beat0", 32'(obs_wr), 32'd1);
    advance_din();
    cycle();
    check("bp_beat1", 32'(obs_wr), 32'd1);
    advance_din();
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_stall_wr",   32'(obs_wr),    32'd0);
      check("bp_stall_own",  32'(obs_owner), 32'd1);
      check("bp_stall_busy", 32'(obs_busy),  32'd1);
    end
    bus.fifo_full = 1'b0;
    cycle();
    check("bp_beat2", 32'(obs_wr), 32'd1);
    advance_din();
    cycle();
    check("bp_beat3", 32'(obs_wr), 32'd1);
    advance_din();
    cycle();
    check("bp_idle", 32'(obs_busy), 32'd0);
    bus.req = '0;
    cycle();

    // Early drop by owner 3; requester 0 wins next.
    do_reset();
    bus.req = 4'b1000;
    cycle();
    cycle();
    check("drop_beat", 32'(obs_ack), 32'b1000);
    advance_din();
    bus.req = 4'b0001;
    cycle();
    check("drop_nowr",  32'(obs_wr),    32'd0);
    check("drop_owner", 32'(obs_owner), 32'd3);
    cycle();
    check("drop_idle", 32'(obs_busy), 32'd0);
    cycle();
    check("drop_next", 32'(obs_ack), 32'b0001);
    bus.req = '0;
    cycle();
    cycle();

    // Async reset in the middle of owner 2's burst.
    do_reset();
    bus.req = 4'b0100;
    cycle();
    cycle();
    advance_din();
    cycle();
    advance_din();
    #2;
    check("arst_pre_busy", 32'(bus.busy),    32'd1);
    check("arst_pre_wr",   32'(bus.fifo_wr), 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_busy", 32'(bus.busy),     32'd0);
    check("arst_wr",   32'(bus.fifo_wr),  32'd0);
    check("arst_ack",  32'(bus.ack),      32'd0);
    check("arst_din",  32'(bus.fifo_din), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req = 4'b1111;
    cycle();
    cycle();
    check("arst_restart", 32'(obs_owner), 32'd0);
    check("arst_restart_ack", 32'(obs_ack), 32'b0001);
    bus.req = '0;
    cycle();
    cycle();

    // Randomized traffic following the requester protocol.
    do_reset();
    obs_ack = '0;
    for (int k = 0; k < 800; k++) begin
      r = bus.req;
      for (int i = 0; i < NREQ; i++) begin
        if (r[i] && !obs_ack[i]) begin
          if ($urandom_range(0, 19) == 0) r[i] = 1'b0;
        end else begin
          r[i]   = ($urandom_range(0, 1) == 1);
          din[i] = 8'($urandom);
        end
      end
      bus.req       = r;
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      if (k % 200 == 199) do_reset();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
